// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: byte-serial main-memory controller for the RISC-V core.
// Arbitrates between the load/store data port and the instruction-fetch port and
// drives an 8-bit RAM/IO bus. The controller issues one byte address per cycle. Read
// bytes come back one cycle after their address. Writes to the IO region stall while
// the IO buffer is full.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   rdy                global ready; low freezes every register
//   flush              branch-mispredict flush; abandons reads and fetches
//   d_req_* / d_resp_* data port (read/write, 1..4 bytes, little-endian)
//   i_req_* / i_resp_* fetch port (LINE_BYTES bytes per request)
//   io_buffer_full     IO write FIFO full
//   mem_din/mem_dout/mem_a/mem_wr   8-bit RAM/IO bus
module mem_ctrl_arb #(
  parameter int         ADDR_W     = 32,
  parameter int         LINE_BYTES = 4,
  parameter int         ARB_RR     = 1,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    d_req_valid,
  input  logic                    d_req_we,
  input  logic [2:0]              d_req_len,
  input  logic [ADDR_W-1:0]       d_req_addr,
  input  logic [31:0]             d_req_wdata,
  output logic                    d_req_ready,
  output logic                    d_resp_valid,
  output logic [31:0]             d_resp_rdata,
  input  logic                    i_req_valid,
  input  logic [ADDR_W-1:0]       i_req_addr,
  output logic                    i_req_ready,
  output logic                    i_resp_valid,
  output logic [LINE_BYTES*8-1:0] i_resp_data,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr
);

  localparam int LINE_W    = LINE_BYTES * 8;
  localparam int BUF_BYTES = (LINE_BYTES > 4) ? LINE_BYTES : 4;
  localparam int BUF_W     = BUF_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                is_fetch_q, is_fetch_d;   // current read belongs to the fetch port
  logic                last_d_q, last_d_d;       // data port was served last
  logic [4:0]          len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          cur_idx_q, cur_idx_d;     // byte currently on the bus
  logic [4:0]          cap_idx_q, cap_idx_d;     // bytes received so far
  logic                rd_bus_q, rd_bus_d;       // bus carries a read address this cycle
  logic                cap_vld_q, cap_vld_d;     // mem_din carries a byte to capture
  logic [BUF_W-1:0]    line_buf_q, line_buf_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                d_resp_valid_q, d_resp_valid_d;
  logic [31:0]         d_resp_rdata_q, d_resp_rdata_d;
  logic                i_resp_valid_q, i_resp_valid_d;
  logic [LINE_W-1:0]   i_resp_data_q, i_resp_data_d;

  logic                grant_d, grant_i, io_stall, issue_last;
  logic [4:0]          nxt_idx;
  logic [ADDR_W-1:0]   nxt_addr;

  // With round-robin, a contested grant goes to the port not served last.
  assign grant_d = d_req_valid && (!i_req_valid || (ARB_RR == 0) || !last_d_q);
  assign grant_i = i_req_valid && !grant_d;

  assign d_req_ready = !rst && (state_q == S_IDLE) && rdy && !flush && grant_d;
  assign i_req_ready = !rst && (state_q == S_IDLE) && rdy && !flush && grant_i;

  // An IO-region write byte waits on the bus while the IO buffer is full.
  assign io_stall   = (state_q == S_WRITE) && (mem_a_q[17:16] == IO_BASE_HI) && io_buffer_full;
  assign issue_last = (cur_idx_q == (len_q - 5'd1));
  assign nxt_idx    = cur_idx_q + 5'd1;
  assign nxt_addr   = base_q + ADDR_W'(nxt_idx);

  // Pause masks the strobes; a pending response pulse is kept until rdy returns.
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q && rdy && !io_stall;
  assign d_resp_valid = d_resp_valid_q && rdy;
  assign d_resp_rdata = d_resp_rdata_q;
  assign i_resp_valid = i_resp_valid_q && rdy;
  assign i_resp_data  = i_resp_data_q;

  // Next-state, byte issue, byte capture and response generation.
  always_comb begin
    state_d        = state_q;
    is_fetch_d     = is_fetch_q;
    last_d_d       = last_d_q;
    len_d          = len_q;
    base_d         = base_q;
    wdata_d        = wdata_q;
    cur_idx_d      = cur_idx_q;
    cap_idx_d      = cap_idx_q;
    rd_bus_d       = rd_bus_q;
    cap_vld_d      = cap_vld_q;
    line_buf_d     = line_buf_q;
    mem_a_d        = mem_a_q;
    mem_dout_d     = mem_dout_q;
    mem_wr_d       = mem_wr_q;
    d_resp_valid_d = 1'b0;
    d_resp_rdata_d = d_resp_rdata_q;
    i_resp_valid_d = 1'b0;
    i_resp_data_d  = i_resp_data_q;
    // Flush outranks rdy: a read is abandoned even while the block is paused.
    if (!rdy && !(flush && (state_q == S_READ))) begin
      d_resp_valid_d = d_resp_valid_q;
      i_resp_valid_d = i_resp_valid_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush && grant_d) begin
            last_d_d   = 1'b1;
            is_fetch_d = 1'b0;
            len_d      = {2'b00, d_req_len};
            base_d     = d_req_addr;
            wdata_d    = d_req_wdata;
            cur_idx_d  = 5'd0;
            cap_idx_d  = 5'd0;
            line_buf_d = '0;
            mem_a_d    = d_req_addr;
            if (d_req_we) begin
              state_d    = S_WRITE;
              mem_wr_d   = 1'b1;
              mem_dout_d = d_req_wdata[7:0];
            end else begin
              state_d  = S_READ;
              rd_bus_d = 1'b1;
            end
          end else if (!flush && grant_i) begin
            last_d_d   = 1'b0;
            is_fetch_d = 1'b1;
            len_d      = 5'(LINE_BYTES);
            base_d     = i_req_addr;
            cur_idx_d  = 5'd0;
            cap_idx_d  = 5'd0;
            line_buf_d = '0;
            mem_a_d    = i_req_addr;
            state_d    = S_READ;
            rd_bus_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_READ: begin
          if (flush) begin
            state_d   = S_IDLE;
            rd_bus_d  = 1'b0;
            cap_vld_d = 1'b0;
            mem_a_d   = '0;
          end else begin
            cap_vld_d = rd_bus_q;
            if (rd_bus_q) begin
              if (issue_last) begin
                rd_bus_d = 1'b0;
                mem_a_d  = '0;
              end else begin
                cur_idx_d = nxt_idx;
                mem_a_d   = nxt_addr;
              end
            end else begin
              mem_a_d = '0;
            end
            if (cap_vld_q) begin
              line_buf_d[{cap_idx_q, 3'b000} +: 8] = mem_din;
              cap_idx_d = cap_idx_q + 5'd1;
              if (cap_idx_q == (len_q - 5'd1)) begin
                state_d = S_IDLE;
                if (is_fetch_q) begin
                  i_resp_valid_d = 1'b1;
                  i_resp_data_d  = line_buf_d[LINE_W-1:0];
                end else begin
                  d_resp_valid_d = 1'b1;
                  d_resp_rdata_d = line_buf_d[31:0];
                end
              end else begin
                state_d = S_READ;
              end
            end else begin
              state_d = S_READ;
            end
          end
        end
        S_WRITE: begin
          if (!io_stall) begin
            if (issue_last) begin
              state_d        = S_IDLE;
              mem_a_d        = '0;
              mem_dout_d     = 8'h00;
              mem_wr_d       = 1'b0;
              d_resp_valid_d = 1'b1;
              d_resp_rdata_d = 32'h0000_0000;
            end else begin
              cur_idx_d  = nxt_idx;
              mem_a_d    = nxt_addr;
              mem_dout_d = wdata_q[{nxt_idx[1:0], 3'b000} +: 8];
            end
          end else begin
            cur_idx_d = cur_idx_q;
          end
        end
        default: begin
          state_d  = S_IDLE;
          rd_bus_d = 1'b0;
          mem_wr_d = 1'b0;
          mem_a_d  = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      is_fetch_q     <= 1'b0;
      last_d_q       <= 1'b0;
      len_q          <= 5'd0;
      base_q         <= '0;
      wdata_q        <= 32'h0000_0000;
      cur_idx_q      <= 5'd0;
      cap_idx_q      <= 5'd0;
      rd_bus_q       <= 1'b0;
      cap_vld_q      <= 1'b0;
      line_buf_q     <= '0;
      mem_a_q        <= '0;
      mem_dout_q     <= 8'h00;
      mem_wr_q       <= 1'b0;
      d_resp_valid_q <= 1'b0;
      d_resp_rdata_q <= 32'h0000_0000;
      i_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      is_fetch_q     <= is_fetch_d;
      last_d_q       <= last_d_d;
      len_q          <= len_d;
      base_q         <= base_d;
      wdata_q        <= wdata_d;
      cur_idx_q      <= cur_idx_d;
      cap_idx_q      <= cap_idx_d;
      rd_bus_q       <= rd_bus_d;
      cap_vld_q      <= cap_vld_d;
      line_buf_q     <= line_buf_d;
      mem_a_q        <= mem_a_d;
      mem_dout_q     <= mem_dout_d;
      mem_wr_q       <= mem_wr_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_rdata_q <= d_resp_rdata_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
`timescale 1ns/1ps
module tb_mem_ctrl_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush;
  logic        d_req_valid, d_req_we, d_req_ready, d_resp_valid;
  logic [2:0]  d_req_len;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_data;
  logic        io_buffer_full, mem_wr;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;

  // second instance with fixed data-port priority
  logic        u1_d_valid, u1_i_valid, u1_d_ready, u1_i_ready;
  logic        u1_d_resp_valid, u1_i_resp_valid, u1_mem_wr;
  logic [31:0] u1_d_rdata, u1_i_data, u1_mem_a;
  logic [7:0]  u1_mem_dout;

  mem_ctrl_arb #(.ADDR_W(32), .LINE_BYTES(4), .ARB_RR(1), .IO_BASE_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_len(d_req_len),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  mem_ctrl_arb #(.ADDR_W(32), .LINE_BYTES(4), .ARB_RR(0), .IO_BASE_HI(2'b11)) u1 (
    .clk(clk), .rst(rst), .rdy(1'b1), .flush(1'b0),
    .d_req_valid(u1_d_valid), .d_req_we(1'b0), .d_req_len(3'd1),
    .d_req_addr(32'h0000_0000), .d_req_wdata(32'h0000_0000), .d_req_ready(u1_d_ready),
    .d_resp_valid(u1_d_resp_valid), .d_resp_rdata(u1_d_rdata),
    .i_req_valid(u1_i_valid), .i_req_addr(32'h0000_0040), .i_req_ready(u1_i_ready),
    .i_resp_valid(u1_i_resp_valid), .i_resp_data(u1_i_data),
    .io_buffer_full(1'b0), .mem_din(8'h00), .mem_dout(u1_mem_dout),
    .mem_a(u1_mem_a), .mem_wr(u1_mem_wr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte at address a is {n,n}, n = a[3:0] + a[7:4] + 1; frozen while rdy=0
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [3:0] n;
    n = a[3:0] + a[7:4] + 4'd1;
    return {n, n};
  endfunction
  always @(posedge clk) if (rdy) mem_din <= ram_byte(mem_a);

  typedef struct { int cyc; logic [31:0] a; logic [31:0] d; bit chk_d; } exp_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;
  exp_t dq[$];
  exp_t iq[$];
  exp_t wq[$];
  chk_t cq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a bus write.
  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    if (d_resp_valid) begin
      if (dq.size() == 0) cmp("d_resp_unexpected", 64'd1, 64'd0);
      else begin
        e = dq.pop_front();
        cmp("d_resp_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk_d) cmp("d_resp_rdata", {32'd0, d_resp_rdata}, {32'd0, e.d});
      end
    end
    if (i_resp_valid) begin
      if (iq.size() == 0) cmp("i_resp_unexpected", 64'd1, 64'd0);
      else begin
        e = iq.pop_front();
        cmp("i_resp_cycle", 64'(cyc), 64'(e.cyc));
        cmp("i_resp_data", {32'd0, i_resp_data}, {32'd0, e.d});
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) cmp("mem_wr_unexpected", {mem_a, 24'd0, mem_dout}, 64'd0);
      else begin
        e = wq.pop_front();
        cmp("mem_wr_cycle", 64'(cyc), 64'(e.cyc));
        cmp("mem_wr_addr_data", {mem_a, 24'd0, mem_dout}, {e.a, 24'd0, e.d[7:0]});
      end
    end
    while (cq.size() > 0) begin
      c = cq.pop_front();
      cmp(c.name, c.act, c.exp);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_chk(input string n, input logic [63:0] a, input logic [63:0] e);
    cq.push_back('{n, a, e});
  endtask

  task automatic push_d(input int c, input logic [31:0] d, input bit chk);
    dq.push_back('{c, 32'd0, d, chk});
  endtask

  task automatic push_i(input int c, input logic [31:0] d);
    iq.push_back('{c, 32'd0, d, 1'b1});
  endtask

  task automatic push_w(input int c, input logic [31:0] a, input logic [7:0] b);
    wq.push_back('{c, a, {24'd0, b}, 1'b1});
  endtask

  // Waits (bounded) for a handshake on either port; returns the cycle it happened in.
  task automatic wait_hs(output bit gd, output bit gi, output int t);
    gd = 1'b0; gi = 1'b0; t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_req_valid && d_req_ready) begin gd = 1'b1; t = cyc; break; end
      if (i_req_valid && i_req_ready) begin gi = 1'b1; t = cyc; break; end
    end
    if (t < 0) expect_chk("handshake_timeout", 64'd0, 64'd1);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gd, gi, exp_d;
    int t, t2;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_len = 3'd4;
    d_req_addr = 32'h100; d_req_wdata = 32'h0;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    u1_d_valid = 1'b0; u1_i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_chk("reset_ready", {62'd0, d_req_ready, i_req_ready}, 64'd0);
    expect_chk("reset_bus", {mem_a, mem_dout, mem_wr, d_resp_valid, i_resp_valid, 21'd0}, 64'd0);
    expect_chk("reset_resp_data", {d_resp_rdata, i_resp_data}, 64'd0);
    d_req_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // 1: data read len=4 at 0x100
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_len = 3'd4; d_req_addr = 32'h100;
    wait_hs(gd, gi, t);
    d_req_valid = 1'b0;
    expect_chk("read_grant", {63'd0, gd}, 64'd1);
    expect_chk("read_first_addr", {32'd0, mem_a}, 64'h100);
    push_d(t + 6, 32'h4433_2211, 1'b1);
    repeat (8) next_cycle();

    // 2: fetch at 0x0 flushed at t+3, new fetch accepted at t+4
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    wait_hs(gd, gi, t);
    i_req_valid = 1'b0;
    expect_chk("fetch_grant", {63'd0, gi}, 64'd1);
    next_cycle();
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    expect_chk("flush_idle_bus", {mem_a, 31'd0, mem_wr}, 64'd0);
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    wait_hs(gd, gi, t2);
    i_req_valid = 1'b0;
    expect_chk("flush_refetch_cycle", 64'(t2), 64'(t + 4));
    push_i(t2 + 6, 32'h5544_3322);
    repeat (8) next_cycle();

    // 3: round-robin, both ports valid: D, I, D
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_len = 3'd1; d_req_addr = 32'h105;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      wait_hs(gd, gi, t);
      exp_d = (k != 1);
      expect_chk("rr_grant", {62'd0, gd, gi}, exp_d ? 64'd2 : 64'd1);
      if (exp_d) push_d(t + 3, 32'h0000_0066, 1'b1);
      else       push_i(t + 6, 32'h5544_3322);
      if (k == 2) begin d_req_valid = 1'b0; i_req_valid = 1'b0; end
    end
    repeat (6) next_cycle();

    // 4: IO write with back-pressure for t+1..t+3
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_len = 3'd2;
    d_req_addr = 32'h0003_0000; d_req_wdata = 32'h0000_BEEF;
    wait_hs(gd, gi, t);
    d_req_valid = 1'b0;
    io_buffer_full = 1'b1;
    push_w(t + 4, 32'h0003_0000, 8'hEF);
    push_w(t + 5, 32'h0003_0001, 8'hBE);
    push_d(t + 6, 32'h0, 1'b0);
    repeat (3) next_cycle();
    io_buffer_full = 1'b0;
    repeat (5) next_cycle();

    // 5: rdy low for 3 cycles mid-read
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_len = 3'd4; d_req_addr = 32'h234;
    wait_hs(gd, gi, t);
    d_req_valid = 1'b0;
    push_d(t + 9, 32'hBBAA_9988, 1'b1);
    next_cycle();
    rdy = 1'b0;
    next_cycle();
    next_cycle();
    expect_chk("pause_hold_addr", {32'd0, mem_a}, 64'h235);
    next_cycle();
    rdy = 1'b1;
    repeat (10) next_cycle();

    // 6: write len=4 wrapping the top of the address space; flush mid-write is ignored
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_len = 3'd4;
    d_req_addr = 32'hFFFF_FFFE; d_req_wdata = 32'hA1B2_C3D4;
    wait_hs(gd, gi, t);
    d_req_valid = 1'b0;
    push_w(t + 1, 32'hFFFF_FFFE, 8'hD4);
    push_w(t + 2, 32'hFFFF_FFFF, 8'hC3);
    push_w(t + 3, 32'h0000_0000, 8'hB2);
    push_w(t + 4, 32'h0000_0001, 8'hA1);
    push_d(t + 5, 32'h0, 1'b0);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    repeat (6) next_cycle();

    // 7: fixed priority instance: D, D, D while both valid
    u1_d_valid = 1'b1; u1_i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gd = 1'b0; gi = 1'b0;
      for (int w = 0; w < 40; w++) begin
        @(negedge clk);
        if (u1_d_ready) begin gd = 1'b1; break; end
        if (u1_i_ready) begin gi = 1'b1; break; end
      end
      expect_chk("fixed_grant", {62'd0, gd, gi}, 64'd2);
      next_cycle();
    end
    u1_d_valid = 1'b0; u1_i_valid = 1'b0;

    repeat (3) next_cycle();
    expect_chk("d_resp_left", 64'(dq.size()), 64'd0);
    expect_chk("i_resp_left", 64'(iq.size()), 64'd0);
    expect_chk("mem_wr_left", 64'(wq.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
